// File: rtl/ghostbus_host_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ghostbus_host_pkg                                          |
// | Brief   : FSM state encoding and read-latency range check shared by  |
// |           the ghostbus host sequencer.                               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ghostbus_host_pkg;

  // State encodings, two bits wide
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_RESP  = ST_RESP
  } state_e;

  // Read latency must fit the 4-bit wait counter and be at least one cycle
  localparam int unsigned RL_MIN = 1;
  localparam int unsigned RL_MAX = 15;

  function automatic bit rl_legal(input int unsigned rl);
    return (rl >= RL_MIN) && (rl <= RL_MAX);
  endfunction

endpackage : ghostbus_host_pkg
`default_nettype wire

// File: rtl/ghostbus_host_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ghostbus_host_seq                                          |
// | Brief   : Host end of the ghostbus. Converts valid/ready requests    |
// |           into one-cycle gb_we/gb_re strobes, captures read data a   |
// |           fixed RL cycles after gb_re and returns one response per   |
// |           beat on a valid/ready stream. At most one beat in flight.  |
// | Options : GHOSTBUS_HOST_BURST_EN - reads issue req_len+1 beats with  |
// |           incrementing (wrapping) address; rsp_last on final beat.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ghostbus_host_seq
  import ghostbus_host_pkg::*;
#(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32,
  parameter int unsigned RL = 2,
  parameter int unsigned LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [LW-1:0] req_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_last,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_rdata,
  output logic          busy
);

  // Reject an out-of-range read latency at elaboration
  if (!rl_legal(RL)) begin : g_rl_check
    $error("ghostbus_host_seq: RL must be within 1..15");
  end

  localparam logic [3:0] RL_LOAD = 4'(RL);

  state_e          state_q;
  logic            req_ready_q;
  logic            we_q;
  logic [3:0]      cnt_q;
  logic            rsp_valid_q;
  logic            rsp_we_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_last_q;
  logic [AW-1:0]   gb_addr_q;
  logic [DW-1:0]   gb_wdata_q;
  logic            gb_we_q;
  logic            gb_re_q;
  logic            busy_q;

`ifdef GHOSTBUS_HOST_BURST_EN
  // Remaining beats after the current one
  logic [LW-1:0]   beats_q;
`else
  logic            w_unused_len;
  assign w_unused_len = ^req_len;
`endif

  // Sequencer FSM: all outputs registered, strobes only ever leave IDLE/RESP into ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_last_q  <= 1'b0;
      gb_addr_q   <= '0;
      gb_wdata_q  <= '0;
      gb_we_q     <= 1'b0;
      gb_re_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef GHOSTBUS_HOST_BURST_EN
      beats_q     <= '0;
`endif
    end else begin
      // Strobes are single-cycle by default
      gb_we_q <= 1'b0;
      gb_re_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            gb_addr_q   <= req_addr;
            gb_wdata_q  <= req_wdata;
            gb_we_q     <= req_we;
            gb_re_q     <= !req_we;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
`ifdef GHOSTBUS_HOST_BURST_EN
            // Writes are always a single beat
            beats_q     <= req_we ? '0 : req_len;
`endif
          end
        end

        S_ISSUE: begin
          if (we_q) begin
            // Write completes immediately; response carries no data
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_last_q  <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q   <= RL_LOAD;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          // cnt_q==1 marks the cycle RL cycles after the gb_re cycle
          if (cnt_q == 4'd1) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= gb_rdata;
`ifdef GHOSTBUS_HOST_BURST_EN
            rsp_last_q  <= (beats_q == '0);
`else
            rsp_last_q  <= 1'b1;
`endif
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_RESP: begin
          // Next beat is only issued once this response has been taken
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (!rsp_last_q) begin
              gb_re_q   <= 1'b1;
              gb_addr_q <= gb_addr_q + AW'(1);
`ifdef GHOSTBUS_HOST_BURST_EN
              beats_q   <= beats_q - LW'(1);
`endif
              state_q   <= S_ISSUE;
            end else begin
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_last  = rsp_last_q;
  assign gb_addr   = gb_addr_q;
  assign gb_wdata  = gb_wdata_q;
  assign gb_we     = gb_we_q;
  assign gb_re     = gb_re_q;
  assign busy      = busy_q;

endmodule : ghostbus_host_seq
`default_nettype wire

// File: tb/tb_ghostbus_host_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ghostbus_host_seq                                       |
// | Brief   : Self-checking bench for ghostbus_host_seq. Randomized      |
// |           requests checked against a transaction-level model of the |
// |           expected strobes, latencies and responses.                 |
// | Options : GHOSTBUS_HOST_BURST_EN - enables burst read expectations.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ghostbus_host_seq;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 2;
  localparam int unsigned LW = 8;
`ifdef GHOSTBUS_HOST_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [LW-1:0] req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_we;
  logic          gb_re;
  logic [DW-1:0] gb_rdata;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int strobes_seen = 0;
  int strobes_exp = 0;

  ghostbus_host_seq #(.AW(AW), .DW(DW), .RL(RL), .LW(LW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_rdata (rsp_rdata),
    .rsp_last  (rsp_last),
    .gb_addr   (gb_addr),
    .gb_wdata  (gb_wdata),
    .gb_we     (gb_we),
    .gb_re     (gb_re),
    .gb_rdata  (gb_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus slave stub: read data for an address is only valid in the cycle RL cycles after gb_re
  function automatic logic [DW-1:0] stub_data(input logic [AW-1:0] a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h0000_0042;
  endfunction

  bit            pend_v = 1'b0;
  int            pend_c;
  logic [AW-1:0] pend_a;

  always @(negedge clk) begin
    if (rst) pend_v = 1'b0;
    if (gb_re) begin
      pend_v = 1'b1;
      pend_c = cyc;
      pend_a = gb_addr;
    end
    if (pend_v && cyc == pend_c + int'(RL)) begin
      gb_rdata = stub_data(pend_a);
      pend_v   = 1'b0;
    end else begin
      gb_rdata = $urandom;
    end
  end

  // Global bus invariants
  always @(negedge clk) begin
    if (gb_we || gb_re) strobes_seen++;
    if (gb_we && gb_re) chk("strobe_exclusive", 1, 0);
  end

  // One request, all its beats, with model-derived timing and data
  task automatic do_req(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [LW-1:0] len, input int stall, input bit early, input bit b2b);
    int            n;
    int            acc;
    int            ref_c;
    int            st_c;
    int            beats;
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    if (!req_ready) return;
    if (b2b) chk("b2b_gap", n, 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_len = len;
    rsp_ready = early;
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom);
    req_wdata = $urandom; req_len = LW'($urandom);
    chk("req_ready_drop", req_ready, 0);
    beats = (we || !BURST) ? 1 : int'(len) + 1;
    strobes_exp += beats;
    ref_c = acc;
    for (int b = 0; b < beats; b++) begin
      a = addr + AW'(b);
      n = 0;
      while (!(gb_we || gb_re) && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("strobe_latency", cyc - ref_c, 0);
      if (n >= 40) return;
      st_c = cyc;
      chk("gb_we", gb_we, we);
      chk("gb_re", gb_re, !we);
      chk("gb_addr", gb_addr, a);
      if (we) chk("gb_wdata", gb_wdata, wd);
      chk("busy_active", busy, 1);
      n = 0;
      while (!rsp_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("rsp_latency", cyc - st_c, we ? 1 : RL + 1);
      if (n >= 40) return;
      exp_d = we ? '0 : stub_data(a);
      chk("rsp_we", rsp_we, we);
      chk("rsp_rdata", rsp_rdata, exp_d);
      chk("rsp_last", rsp_last, (b == beats - 1));
      if (!early) begin
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          chk("stall_valid", rsp_valid, 1);
          chk("stall_rdata", rsp_rdata, exp_d);
          chk("stall_last", rsp_last, (b == beats - 1));
          chk("stall_nostrobe", gb_we | gb_re, 0);
          chk("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      ref_c = cyc;
      chk("rsp_consumed", rsp_valid, 0);
      if (!early) rsp_ready = 1'b0;
    end
    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int            seen;
    logic [AW-1:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_len = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_gb_we", gb_we, 0);
    chk("rst_gb_re", gb_re, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gb_addr", gb_addr, 0);
    rst = 1'b0;

    // Directed: single write, single read, read with held-off response
    do_req(1'b1, 24'h000040, 32'hDEAD_BEEF, 8'd0, 0, 1'b0, 1'b0);
    do_req(1'b0, 24'h000010, 32'h0, 8'd0, 0, 1'b0, 1'b1);
    do_req(1'b0, 24'h000123, 32'h0, 8'd0, 5, 1'b0, 1'b1);

    // Reset while waiting for read data
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000077;
    @(negedge clk);
    req_valid = 1'b0;
    strobes_exp++;
    chk("rstw_gb_re", gb_re, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_gb_re_off", gb_re, 0);
    chk("rstw_gb_we_off", gb_we, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_req_ready", req_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < int'(RL) + 4; k++) begin
      @(negedge clk);
      if (rsp_valid || gb_we || gb_re) seen++;
    end
    chk("rstw_no_activity", seen, 0);
    do_req(1'b0, 24'h000077, 32'h0, 8'd0, 1, 1'b0, 1'b0);

`ifdef GHOSTBUS_HOST_BURST_EN
    // Burst read across the address wrap
    do_req(1'b0, 24'hFFFFFE, 32'h0, 8'd3, 0, 1'b0, 1'b1);
    do_req(1'b0, 24'h00ABCD, 32'h0, 8'd2, 2, 1'b0, 1'b1);
`endif

    // Randomized back-to-back traffic
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFFF - AW'($urandom_range(0, 2));
      do_req(1'($urandom), a, $urandom, LW'($urandom_range(0, 3)),
             $urandom_range(0, 3), 1'($urandom), 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("strobe_count", strobes_seen, strobes_exp);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_ghostbus_host_seq
`default_nettype wire
